// File: rtl/mux_n_arb_pkg.sv
// Shared definitions for the N-channel registered mux/arbiter.
package mux_n_arb_pkg;

   // Arbitration mode encodings driven on the mode input.
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Ceiling log2, used to size index fields and to validate SEL_W.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span << 1;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_n_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
   import mux_n_arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int PTR_W = int'(clog2(N))
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_valid
);

   localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [PTR_W-1:0] offset;
   logic             found;
   logic [PTR_W:0]   idx_sum;

   // Rotate the request vector so ptr lands at bit 0, pick the lowest set
   // bit, then rotate the winning offset back into an absolute index.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[N-1:0];
      offset  = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req_rot[i]) begin
            found  = 1'b1;
            offset = i[PTR_W-1:0];
         end
      end
      idx_sum = {1'b0, ptr} + {1'b0, offset};
      if (idx_sum >= N_EXT) begin
         idx_sum = idx_sum - N_EXT;
      end
      grant_idx   = idx_sum[PTR_W-1:0];
      grant_valid = found;
   end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel registered multiplexer with valid/ready handshakes and
// fixed-select or round-robin arbitration in front of a one-entry output reg.
module mux_n_arb
   import mux_n_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 32,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_chan,
   output logic             out_valid,
   input  logic             out_ready
);

   if (SEL_W != int'(clog2(N))) begin : g_sel_w_check
      $error("mux_n_arb: SEL_W must equal clog2(N)");
   end

   if (N < 2 || N > 16) begin : g_n_range_check
      $error("mux_n_arb: N must be in 2..16");
   end

   localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(N - 1);

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
   logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

   logic             fixed_valid;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_valid;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_valid;
   logic             free;
   logic [W-1:0]     grant_data;

   rr_arbiter #(
      .N (N)
   ) u_rr_arbiter (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   // FIXED-mode grant: only sel's own valid matters; an out-of-range sel
   // matches no channel and therefore never grants.
   always_comb begin
      fixed_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == i[SEL_W-1:0] && in_valid[i]) begin
            fixed_valid = 1'b1;
         end
      end
   end

   // Choose the active arbitration result for this cycle.
   always_comb begin
      if (mode == MODE_RR) begin
         grant_idx   = rr_idx;
         grant_valid = rr_valid;
      end else begin
         grant_idx   = sel;
         grant_valid = fixed_valid;
      end
   end

   // Output register can take a beat when empty or being drained this cycle.
   always_comb begin
      free = !out_valid_q || out_ready;
   end

   // One-hot ready to the granted channel; suppressed while reset is high.
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready[i] = !reset && free && grant_valid &&
                       (grant_idx == i[SEL_W-1:0]);
      end
   end

   // Data path mux for the granted channel.
   always_comb begin
      grant_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_idx == i[SEL_W-1:0]) begin
            grant_data = in_data[i*W +: W];
         end
      end
   end

   // Next-state for the output register and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_ptr_d    = rr_ptr_q;
      if (free) begin
         if (grant_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            if (mode == MODE_RR) begin
               rr_ptr_d = (grant_idx == LAST_CHAN) ? '0 : grant_idx + 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb (N=4 main instance, N=3 for range checks).
module tb_mux_n_arb;

   localparam logic [31:0] DA = 32'haaaaaaaa;
   localparam logic [31:0] DB = 32'hbbbbbbbb;
   localparam logic [31:0] DC = 32'hcccccccc;
   localparam logic [31:0] DD = 32'hdddddddd;

   logic         clk = 1'b0;
   logic         reset;
   logic         mode;
   logic [1:0]   sel;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_chan;
   logic         out_valid;
   logic         out_ready;

   logic         mode3;
   logic [1:0]   sel3;
   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [31:0]  out_data3;
   logic [1:0]   out_chan3;
   logic         out_valid3;
   logic         out_ready3;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit          m_valid;
   logic [31:0] m_data;
   logic [1:0]  m_chan;
   int          m_ptr;

   always #5 clk = ~clk;

   mux_n_arb #(.N(4), .W(32), .SEL_W(2)) dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   mux_n_arb #(.N(3), .W(32), .SEL_W(2)) dut3 (
      .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   // Winning channel by the arbitration rules, or -1 for no grant.
   function automatic int model_grant(input bit md, input int s,
                                      input logic [3:0] v, input int p);
      if (!md) begin
         if (s < 4 && v[s]) return s;
         return -1;
      end
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      int g;
      bit free;
      free = !m_valid || out_ready;
      g = model_grant(mode, int'(sel), in_valid, m_ptr);
      if (free && g >= 0 && !reset) return 4'(1 << g);
      return 4'b0000;
   endfunction

   // Clock one edge and advance the model with the inputs seen at that edge.
   task automatic advance();
      int g;
      bit free;
      free = !m_valid || out_ready;
      g = model_grant(mode, int'(sel), in_valid, m_ptr);
      @(posedge clk);
      if (free) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*32 +: 32];
            m_chan  = 2'(g);
            if (mode) m_ptr = (g + 1) % 4;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = '0;
      m_ptr   = 0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
         errors++;
         $display("FAIL reset_initial: valid=%b data=%h chan=%0d required 0/0/0",
                  out_valid, out_data, out_chan);
      end
      @(negedge clk);
      reset = 1'b0;
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DB) begin
         errors++;
         $display("FAIL reset_preload: valid=%b data=%h required 1/%h",
                  out_valid, out_data, DB);
      end
      @(negedge clk);
      out_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
         errors++;
         $display("FAIL reset_async: valid=%b data=%h chan=%0d required 0/0/0",
                  out_valid, out_data, out_chan);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b required 0000", in_ready);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_fixed();
      logic [31:0] exp_d [4];
      logic [31:0] tail_data;
      exp_d[0] = DA; exp_d[1] = DB; exp_d[2] = DC; exp_d[3] = DD;
      @(negedge clk);
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL fixed_ready: in_ready=%b required 0100", in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DC || out_chan !== 2'd2) begin
         errors++;
         $display("FAIL fixed_sel2: valid=%b data=%h chan=%0d required 1/%h/2",
                  out_valid, out_data, out_chan, DC);
      end
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         sel = (s == 4) ? 2'd1 : 2'(s);
         advance();
         tail_data = exp_d[(s == 4) ? 1 : s];
         checks++;
         if (out_data !== tail_data || out_chan !== sel || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fixed_step%0d: data=%h chan=%0d required %h/%0d",
                     s, out_data, out_chan, tail_data, sel);
         end
      end
   endtask

   task automatic test_rr();
      int exp_all [6] = '{0, 1, 2, 3, 0, 1};
      int exp_sub [3] = '{3, 1, 3};
      logic [31:0] exp_d [4];
      exp_d[0] = DA; exp_d[1] = DB; exp_d[2] = DC; exp_d[3] = DD;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
         advance();
         checks++;
         if (int'(out_chan) != exp_all[k] || out_data !== exp_d[exp_all[k]]) begin
            errors++;
            $display("FAIL rr_all%0d: chan=%0d data=%h required %0d/%h",
                     k, out_chan, out_data, exp_all[k], exp_d[exp_all[k]]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 4'b1010;
         advance();
         checks++;
         if (int'(out_chan) != exp_sub[k] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_sub%0d: chan=%0d valid=%b required %0d/1",
                     k, out_chan, out_valid, exp_sub[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
      advance();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 4'b1111; out_ready = 1'b0;
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready%0d: in_ready=%b required 0000", k, in_ready);
         end
         advance();
         checks++;
         if (out_valid !== 1'b1 || out_data !== DB || out_chan !== 2'd1) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b data=%h chan=%0d required 1/%h/1",
                     k, out_valid, out_data, out_chan, DB);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL bp_release_ready: in_ready=%b required 0100", in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DC || out_chan !== 2'd2) begin
         errors++;
         $display("FAIL bp_release: valid=%b data=%h chan=%0d required 1/%h/2",
                  out_valid, out_data, out_chan, DC);
      end
   endtask

   task automatic test_pop_push();
      @(negedge clk);
      in_valid = 4'b1000; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL poppush_ready: in_ready=%b required 1000", in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DD || out_chan !== 2'd3) begin
         errors++;
         $display("FAIL poppush: valid=%b data=%h chan=%0d required 1/%h/3",
                  out_valid, out_data, out_chan, DD);
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      in_valid = 4'b0000; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL idle_ready: in_ready=%b required 0000", in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b0 || out_data !== DD || out_chan !== 2'd3) begin
         errors++;
         $display("FAIL idle: valid=%b data=%h chan=%0d required 0/%h/3",
                  out_valid, out_data, out_chan, DD);
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
      #1;
      checks++;
      if (in_ready3 !== 3'b001) begin
         errors++;
         $display("FAIL oor_load_ready: in_ready=%b required 001", in_ready3);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid3 !== 1'b1 || out_data3 !== DA) begin
         errors++;
         $display("FAIL oor_load: valid=%b data=%h required 1/%h",
                  out_valid3, out_data3, DA);
      end
      @(negedge clk);
      sel3 = 2'd3;
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin
         errors++;
         $display("FAIL oor_ready: in_ready=%b required 000", in_ready3);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== DA) begin
         errors++;
         $display("FAIL oor_drop: valid=%b data=%h required 0/%h",
                  out_valid3, out_data3, DA);
      end
      @(negedge clk);
      in_valid3 = 3'b000;
   endtask

   task automatic test_random();
      logic [3:0] exp_rdy;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         mode      = 1'($urandom_range(0, 1));
         sel       = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
         #1;
         exp_rdy = model_ready();
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rand_ready%0d: in_ready=%b required %b", k, in_ready, exp_rdy);
         end
         advance();
         checks++;
         if (out_valid !== m_valid || out_data !== m_data || out_chan !== m_chan) begin
            errors++;
            $display("FAIL rand_out%0d: valid=%b data=%h chan=%0d required %b/%h/%0d",
                     k, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b1;
      in_data = {DD, DC, DB, DA};
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
      in_data3 = {DC, DB, DA};
      model_reset();
      test_reset();
      test_fixed();
      test_rr();
      test_backpressure();
      test_pop_push();
      test_idle();
      test_out_of_range();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
